// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer with boot, redirect-flush and halt
// handling. It selects the next PC (JALR > JAL > branch > pc+4), detects
// misaligned taken targets, captures the trap PC and counts retired
// instructions.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  // Value retire_cnt takes on reset; non-zero values let a bench reach the wrap point quickly.
  parameter logic [31:0] RETIRE_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        BrTaken,
  input  logic        Jump,
  input  logic        Jalr,
  input  logic [31:0] imm,
  input  logic [31:0] rs1_val,
  input  logic        halt_req,
  input  logic        resume,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_valid,
  output logic        flush,
  output logic        misalign,
  output logic [31:0] trap_pc,
  output logic [1:0]  state,
  output logic [31:0] retire_cnt
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'b00,
    ST_RUN   = 2'b01,
    ST_FLUSH = 2'b10,
    ST_HALT  = 2'b11
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] trap_pc_q, trap_pc_d;
  logic [31:0] retire_cnt_q, retire_cnt_d;
  logic        misalign_q, misalign_d;
  logic        fetch_valid_q, fetch_valid_d;
  logic        flush_q, flush_d;

  logic        fire_s;
  logic        taken_s;
  logic [31:0] jalr_sum_s;
  logic [31:0] target_s;
  logic [31:0] pc_plus4_s;

  // Next-PC candidates and fire/taken qualification for the current instruction.
  always_comb begin
    pc_plus4_s = pc_q + 32'd4;
    jalr_sum_s = rs1_val + imm;
    fire_s     = (state_q == ST_RUN) && !stall;
    taken_s    = Jalr || Jump || BrTaken;
    if (Jalr) begin
      target_s = {jalr_sum_s[31:1], 1'b0};
    end else if (Jump || BrTaken) begin
      target_s = pc_q + imm;
    end else begin
      target_s = pc_plus4_s;
    end
  end

  // Sequencer next-state: a misaligned redirect outranks a halt request, which outranks a redirect.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    trap_pc_d    = trap_pc_q;
    retire_cnt_d = retire_cnt_q;
    misalign_d   = misalign_q;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (fire_s) begin
          if (taken_s && (target_s[1:0] != 2'b00)) begin
            trap_pc_d  = pc_q;
            misalign_d = 1'b1;
            state_d    = ST_HALT;
          end else if (halt_req) begin
            trap_pc_d    = pc_q;
            pc_d         = pc_plus4_s;
            state_d      = ST_HALT;
            retire_cnt_d = retire_cnt_q + 32'd1;
          end else if (taken_s) begin
            pc_d         = target_s;
            state_d      = ST_FLUSH;
            retire_cnt_d = retire_cnt_q + 32'd1;
          end else begin
            pc_d         = pc_plus4_s;
            state_d      = ST_RUN;
            retire_cnt_d = retire_cnt_q + 32'd1;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FLUSH: begin
        state_d = ST_RUN;
      end
      ST_HALT: begin
        if (resume) begin
          state_d    = ST_RUN;
          misalign_d = 1'b0;
        end else begin
          state_d = ST_HALT;
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
    fetch_valid_d = (state_d == ST_RUN);
    flush_d       = (state_d == ST_FLUSH);
  end

  // State register with synchronous reset; status outputs are registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_PC;
      trap_pc_q     <= 32'h0000_0000;
      retire_cnt_q  <= RETIRE_RESET;
      misalign_q    <= 1'b0;
      fetch_valid_q <= 1'b0;
      flush_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      trap_pc_q     <= trap_pc_d;
      retire_cnt_q  <= retire_cnt_d;
      misalign_q    <= misalign_d;
      fetch_valid_q <= fetch_valid_d;
      flush_q       <= flush_d;
    end
  end

  assign pc          = pc_q;
  assign pc_plus4    = pc_plus4_s;
  assign fetch_valid = fetch_valid_q;
  assign flush       = flush_q;
  assign misalign    = misalign_q;
  assign trap_pc     = trap_pc_q;
  assign state       = state_q;
  assign retire_cnt  = retire_cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: table-driven directed test of pc_sequencer plus a
// hand-written retire-counter wrap / halt / reset sequence. A second
// instance starts retire_cnt near the wrap point and shares all inputs.
module tb_pc_sequencer;

  localparam logic [31:0] RC2_OFS = 32'hFFFF_FFFD;
  localparam logic [1:0]  B = 2'b00;
  localparam logic [1:0]  R = 2'b01;
  localparam logic [1:0]  F = 2'b10;
  localparam logic [1:0]  H = 2'b11;

  logic        clk = 1'b0;
  logic        rst, stall, br_taken, jump, jalr, halt_req, resume;
  logic [31:0] imm, rs1_val;

  logic [31:0] pc1, pp4_1, trap1, rc1;
  logic        fv1, fl1, mis1;
  logic [1:0]  st1;
  logic [31:0] pc2, pp4_2, trap2, rc2;
  logic        fv2, fl2, mis2;
  logic [1:0]  st2;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        rst, stall, br, jmp, jalr, hreq, res;
    logic [31:0] imm, rs1;
    logic [31:0] e_pc;
    logic [1:0]  e_st;
    logic        e_fv, e_fl, e_mis;
    logic [31:0] e_trap, e_rc;
  } vec_t;

  vec_t vq[$];

  pc_sequencer #(.RESET_PC(32'h0000_0000), .RETIRE_RESET(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .stall(stall), .BrTaken(br_taken), .Jump(jump), .Jalr(jalr),
    .imm(imm), .rs1_val(rs1_val), .halt_req(halt_req), .resume(resume),
    .pc(pc1), .pc_plus4(pp4_1), .fetch_valid(fv1), .flush(fl1), .misalign(mis1),
    .trap_pc(trap1), .state(st1), .retire_cnt(rc1)
  );

  pc_sequencer #(.RESET_PC(32'h0000_0000), .RETIRE_RESET(RC2_OFS)) dut_wrap (
    .clk(clk), .rst(rst), .stall(stall), .BrTaken(br_taken), .Jump(jump), .Jalr(jalr),
    .imm(imm), .rs1_val(rs1_val), .halt_req(halt_req), .resume(resume),
    .pc(pc2), .pc_plus4(pp4_2), .fetch_valid(fv2), .flush(fl2), .misalign(mis2),
    .trap_pc(trap2), .state(st2), .retire_cnt(rc2)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic add(input logic r, s, b, j, jr, h, rs, input logic [31:0] im, r1,
                     input logic [31:0] epc, input logic [1:0] est, input logic efv, efl, emis,
                     input logic [31:0] etrap, erc);
    vec_t v;
    v.rst = r; v.stall = s; v.br = b; v.jmp = j; v.jalr = jr; v.hreq = h; v.res = rs;
    v.imm = im; v.rs1 = r1; v.e_pc = epc; v.e_st = est; v.e_fv = efv; v.e_fl = efl;
    v.e_mis = emis; v.e_trap = etrap; v.e_rc = erc;
    vq.push_back(v);
  endtask

  // Drive inputs (called just after a falling edge), then advance to the next falling edge.
  task automatic step(input logic r, s, b, j, jr, h, rs, input logic [31:0] im, r1);
    rst = r; stall = s; br_taken = b; jump = j; jalr = jr; halt_req = h; resume = rs;
    imm = im; rs1_val = r1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_all(input string tag, input logic [31:0] epc, input logic [1:0] est,
                            input logic efv, efl, emis, input logic [31:0] etrap, erc,
                            input logic [31:0] erc2);
    chk({tag, "_pc"},       pc1,   epc);
    chk({tag, "_pc_plus4"}, pp4_1, epc + 32'd4);
    chk({tag, "_state"},    {30'd0, st1}, {30'd0, est});
    chk({tag, "_fetch_valid"}, {31'd0, fv1}, {31'd0, efv});
    chk({tag, "_flush"},    {31'd0, fl1}, {31'd0, efl});
    chk({tag, "_misalign"}, {31'd0, mis1}, {31'd0, emis});
    chk({tag, "_trap_pc"},  trap1, etrap);
    chk({tag, "_retire"},   rc1,   erc);
    chk({tag, "_w_pc"},     pc2,   epc);
    chk({tag, "_w_pc_plus4"}, pp4_2, epc + 32'd4);
    chk({tag, "_w_state"},  {30'd0, st2}, {30'd0, est});
    chk({tag, "_w_fetch_valid"}, {31'd0, fv2}, {31'd0, efv});
    chk({tag, "_w_flush"},  {31'd0, fl2}, {31'd0, efl});
    chk({tag, "_w_misalign"}, {31'd0, mis2}, {31'd0, emis});
    chk({tag, "_w_trap_pc"}, trap2, etrap);
    chk({tag, "_w_retire"}, rc2,   erc2);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; br_taken = 1'b0; jump = 1'b0; jalr = 1'b0;
    halt_req = 1'b0; resume = 1'b0; imm = 32'd0; rs1_val = 32'd0;

    //   rst s  br j  jr h  res imm            rs1          pc            st fv fl mis trap           rc
    add(1, 0, 0, 0, 0, 0, 0, 32'h0,         32'h0,        32'h0000_0000, B, 0, 0, 0, 32'h0,        32'd0);
    add(0, 0, 0, 0, 0, 0, 0, 32'h0,         32'h0,        32'h0000_0000, R, 1, 0, 0, 32'h0,        32'd0);
    add(0, 0, 0, 0, 0, 0, 0, 32'h0,         32'h0,        32'h0000_0004, R, 1, 0, 0, 32'h0,        32'd1);
    add(0, 0, 0, 0, 0, 0, 0, 32'h0,         32'h0,        32'h0000_0008, R, 1, 0, 0, 32'h0,        32'd2);
    add(0, 0, 0, 0, 0, 0, 0, 32'h0,         32'h0,        32'h0000_000C, R, 1, 0, 0, 32'h0,        32'd3);
    add(0, 0, 0, 0, 0, 0, 0, 32'h0,         32'h0,        32'h0000_0010, R, 1, 0, 0, 32'h0,        32'd4);
    add(0, 0, 1, 0, 0, 0, 0, 32'h20,        32'h0,        32'h0000_0030, F, 0, 1, 0, 32'h0,        32'd5);
    add(0, 1, 0, 0, 0, 0, 0, 32'h0,         32'h0,        32'h0000_0030, R, 1, 0, 0, 32'h0,        32'd5);
    add(0, 0, 0, 1, 1, 0, 0, 32'h4,         32'h101,      32'h0000_0104, F, 0, 1, 0, 32'h0,        32'd6);
    add(0, 0, 0, 0, 0, 0, 0, 32'h0,         32'h0,        32'h0000_0104, R, 1, 0, 0, 32'h0,        32'd6);
    add(0, 0, 0, 1, 0, 0, 0, 32'hFFFF_FF3C, 32'h0,        32'h0000_0040, F, 0, 1, 0, 32'h0,        32'd7);
    add(0, 0, 0, 0, 0, 0, 0, 32'h0,         32'h0,        32'h0000_0040, R, 1, 0, 0, 32'h0,        32'd7);
    add(0, 0, 0, 1, 0, 0, 0, 32'h6,         32'h0,        32'h0000_0040, H, 0, 0, 1, 32'h40,       32'd7);
    add(0, 1, 1, 0, 0, 0, 0, 32'h10,        32'h0,        32'h0000_0040, H, 0, 0, 1, 32'h40,       32'd7);
    add(0, 0, 0, 0, 0, 0, 1, 32'h0,         32'h0,        32'h0000_0040, R, 1, 0, 0, 32'h40,       32'd7);
    add(0, 1, 1, 0, 0, 0, 0, 32'h10,        32'h0,        32'h0000_0040, R, 1, 0, 0, 32'h40,       32'd7);
    add(0, 1, 1, 0, 0, 0, 0, 32'h10,        32'h0,        32'h0000_0040, R, 1, 0, 0, 32'h40,       32'd7);
    add(0, 1, 1, 0, 0, 1, 0, 32'h10,        32'h0,        32'h0000_0040, R, 1, 0, 0, 32'h40,       32'd7);
    add(0, 0, 1, 0, 0, 0, 0, 32'h10,        32'h0,        32'h0000_0050, F, 0, 1, 0, 32'h40,       32'd8);
    add(0, 0, 1, 0, 0, 0, 0, 32'h10,        32'h0,        32'h0000_0050, R, 1, 0, 0, 32'h40,       32'd8);
    add(0, 0, 0, 0, 0, 0, 0, 32'h0,         32'h0,        32'h0000_0054, R, 1, 0, 0, 32'h40,       32'd9);
    add(0, 0, 0, 0, 0, 0, 1, 32'h0,         32'h0,        32'h0000_0058, R, 1, 0, 0, 32'h40,       32'd10);
    add(0, 0, 0, 1, 0, 0, 0, 32'h8,         32'h0,        32'h0000_0060, F, 0, 1, 0, 32'h40,       32'd11);
    add(1, 0, 0, 0, 0, 0, 0, 32'h0,         32'h0,        32'h0000_0000, B, 0, 0, 0, 32'h0,        32'd0);
    add(0, 0, 0, 0, 0, 0, 0, 32'h0,         32'h0,        32'h0000_0000, R, 1, 0, 0, 32'h0,        32'd0);
    add(0, 0, 0, 0, 1, 0, 0, 32'h0,         32'h2,        32'h0000_0000, H, 0, 0, 1, 32'h0,        32'd0);
    add(1, 0, 0, 0, 0, 0, 1, 32'h0,         32'h0,        32'h0000_0000, B, 0, 0, 0, 32'h0,        32'd0);

    @(negedge clk);
    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].rst, vq[i].stall, vq[i].br, vq[i].jmp, vq[i].jalr, vq[i].hreq, vq[i].res,
           vq[i].imm, vq[i].rs1);
      expect_all($sformatf("v%0d", i), vq[i].e_pc, vq[i].e_st, vq[i].e_fv, vq[i].e_fl,
                 vq[i].e_mis, vq[i].e_trap, vq[i].e_rc, vq[i].e_rc + RC2_OFS);
    end

    // Retire-counter wrap on the halting instruction, then reset out of HALT.
    step(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    expect_all("w_boot", 32'h0, R, 1, 0, 0, 32'h0, 32'd0, 32'hFFFF_FFFD);
    step(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    expect_all("w_fire1", 32'h4, R, 1, 0, 0, 32'h0, 32'd1, 32'hFFFF_FFFE);
    step(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    expect_all("w_fire2", 32'h8, R, 1, 0, 0, 32'h0, 32'd2, 32'hFFFF_FFFF);
    step(0, 1, 0, 0, 0, 1, 0, 32'h0, 32'h0);
    expect_all("w_stall_halt", 32'h8, R, 1, 0, 0, 32'h0, 32'd2, 32'hFFFF_FFFF);
    // Halt request together with an aligned branch: halt wins, pc goes to pc+4.
    step(0, 0, 1, 0, 0, 1, 0, 32'h100, 32'h0);
    expect_all("w_halt", 32'hC, H, 0, 0, 0, 32'h8, 32'd3, 32'h0000_0000);
    step(0, 0, 0, 1, 0, 0, 0, 32'h40, 32'h0);
    expect_all("w_halt_hold", 32'hC, H, 0, 0, 0, 32'h8, 32'd3, 32'h0000_0000);
    step(1, 0, 0, 0, 0, 0, 1, 32'h0, 32'h0);
    expect_all("w_reset", 32'h0, B, 0, 0, 0, 32'h0, 32'd0, 32'hFFFF_FFFD);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the PC value loaded on reset.
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold the current instruction; no PC update, no retire.
- BrTaken  in  1  conditional-branch outcome from the branch comparator.
- Jump  in  1  JAL in the current instruction.
- Jalr  in  1  JALR in the current instruction.
- imm  in  32  sign-extended immediate.
- rs1_val  in  32  rs1 operand, used for the JALR target.
- halt_req  in  1  ECALL/EBREAK in the current instruction.
- resume  in  1  leave HALT.
- pc  out  32  current fetch address, registered.
- pc_plus4  out  32  pc+4 mod 2^32, combinational.
- fetch_valid  out  1  the instruction at pc is valid and executing.
- flush  out  1  redirect bubble; discard the fetched word.
- misalign  out  1  sticky flag: a taken target was misaligned.
- trap_pc  out  32  PC of the faulting or halting instruction.
- state  out  2  BOOT=00, RUN=01, FLUSH=10, HALT=11.
- retire_cnt  out  32  count of retired instructions.

Function
REQ-003 SHALL fire an instruction ("fire") only when state==RUN and stall==0; fetch_valid SHALL be 1 exactly when state==RUN.
REQ-004 SHALL select the target with priority Jalr > Jump > BrTaken:
- Jalr: (rs1_val+imm) with bit0 cleared.
- Jump or BrTaken: pc+imm.
- Otherwise: pc_plus4.
- All additions wrap mod 2^32.
REQ-005 SHALL treat an instruction as "taken" when it fires with Jalr, Jump or BrTaken equal to 1.
REQ-006 On a taken fire with target[1:0]==00: pc <= target, state <= FLUSH, retire_cnt increments.
REQ-007 On a taken fire with target[1:0]!=00: pc SHALL hold, trap_pc <= pc, misalign <= 1, state <= HALT, retire_cnt does not increment.
REQ-008 On a not-taken fire without halt_req: pc <= pc_plus4, state stays RUN, retire_cnt increments.
REQ-009 On a fire with halt_req and no misalignment:
- trap_pc <= pc, pc <= pc_plus4, state <= HALT, retire_cnt increments.
- A misaligned taken target SHALL take priority over halt_req (REQ-007 applies).
REQ-010 When stall==1 in RUN: pc, state, retire_cnt and trap_pc SHALL hold, and BrTaken/Jump/Jalr/halt_req SHALL be ignored.
REQ-011 FLUSH SHALL last exactly one cycle regardless of stall.
- flush=1 and fetch_valid=0 during FLUSH.
- Next state is RUN; no retire.
REQ-012 BOOT SHALL last exactly one cycle after reset deassertion, with fetch_valid=0; next state is RUN.
REQ-013 In HALT: fetch_valid=0, pc holds, and stall and the redirect inputs are ignored.
REQ-014 resume=1 in HALT SHALL move to RUN next cycle and clear misalign; resume SHALL be ignored in every other state.
REQ-015 retire_cnt SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-016 flush SHALL be driven from registered state only; no combinational path from inputs to flush, fetch_valid or state.
REQ-017 misalign and trap_pc SHALL change only per REQ-007, REQ-009, REQ-014 and reset.

Reset
REQ-018 rst=1 at a clock edge SHALL set:
- pc=RESET_PC, state=BOOT, fetch_valid=0, flush=0, misalign=0, trap_pc=0, retire_cnt=0.
REQ-019 rst SHALL override all other inputs in the same cycle, including a reset asserted mid-FLUSH or mid-HALT.

Verification
REQ-020 Reset, then 3 non-taken fires -> BOOT 1 cycle; then pc = 0, 4, 8, 12; retire_cnt=3; flush never 1.
REQ-021 pc=0x10, BrTaken=1, imm=0x20 -> next cycle pc=0x30, flush=1, fetch_valid=0; following cycle RUN, retire_cnt+1.
REQ-022 Jalr=1, Jump=1, rs1_val=0x101, imm=0x4 -> pc=0x104, not pc+imm; bit0 cleared.
REQ-023 pc=0x40, Jump=1, imm=0x6 -> state=HALT, misalign=1, trap_pc=0x40, pc=0x40, retire_cnt unchanged; resume=1 -> RUN, misalign=0.
REQ-024 stall=1 for 3 cycles with BrTaken=1 -> pc and retire_cnt constant; release stall -> redirect occurs once.
REQ-025 Preload retire_cnt near 0xFFFF_FFFF via 2 fires, then halt_req -> wraps to 0 correctly, trap_pc = halting pc, pc = trap_pc+4; rst during HALT -> all outputs at reset values.
